// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with valid/ready handshakes on both sides and an illegal-op flag.
// Define IEXT_FUSE_EN to fuse a back-to-back SHIFTL + matching-tag ORLOW into one full-width constant.
module imm_ext_pipe #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [2:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_fused,
    output logic              out_err
);

    // state  | meaning
    // IDLE   | output register free to take the next beat directly
    // PEND   | SHIFTL result parked, waiting to see if the next beat fuses with it
    // HOLD   | pending result emitted; a raw beat waits in the hold register
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [2:0] OP_ZERO   = 3'b000;
    localparam logic [2:0] OP_SIGNED = 3'b001;
    localparam logic [2:0] OP_SHIFTL = 3'b010;
    localparam logic [2:0] OP_ORLOW  = 3'b011;

    state_t              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_imm_q, out_imm_d;
    logic [TAG_W-1:0]    out_tag_q, out_tag_d;
    logic                out_err_q, out_err_d;

    logic                out_free;
    logic                accept;
    logic                take_src;
    logic [IMM_W-1:0]    src_imm;
    logic [2:0]          src_op;
    logic [TAG_W-1:0]    src_tag;
    logic [DATA_W-1:0]   src_val;
    logic                src_err;

`ifdef IEXT_FUSE_EN
    logic                out_fused_q, out_fused_d;
    logic [DATA_W-1:0]   pend_imm_q, pend_imm_d;
    logic [TAG_W-1:0]    pend_tag_q, pend_tag_d;
    logic [IMM_W-1:0]    hold_imm_q, hold_imm_d;
    logic [2:0]          hold_op_q, hold_op_d;
    logic [TAG_W-1:0]    hold_tag_q, hold_tag_d;
`endif

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = !rst && (state_q != S_HOLD) && out_free;
    assign accept   = in_valid && in_ready;

    // The extender sees either the live input beat or, in HOLD, the parked one.
    always_comb begin
        src_imm = in_imm;
        src_op  = in_op;
        src_tag = in_tag;
`ifdef IEXT_FUSE_EN
        if (state_q == S_HOLD) begin
            src_imm = hold_imm_q;
            src_op  = hold_op_q;
            src_tag = hold_tag_q;
        end
`endif
    end

    always_comb begin
        src_val = '0;
        src_err = 1'b0;
        case (src_op)
            OP_ZERO, OP_ORLOW: src_val = {{(DATA_W-IMM_W){1'b0}}, src_imm};
            OP_SIGNED:         src_val = {{(DATA_W-IMM_W){src_imm[IMM_W-1]}}, src_imm};
            OP_SHIFTL:         src_val = {src_imm, {(DATA_W-IMM_W){1'b0}}};
            default:           src_err = 1'b1;
        endcase
    end

    assign take_src = (state_q == S_HOLD) ? out_free : ((state_q == S_IDLE) && accept);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_imm_d   = out_imm_q;
        out_tag_d   = out_tag_q;
        out_err_d   = out_err_q;
`ifdef IEXT_FUSE_EN
        out_fused_d = out_fused_q;
        pend_imm_d  = pend_imm_q;
        pend_tag_d  = pend_tag_q;
        hold_imm_d  = hold_imm_q;
        hold_op_d   = hold_op_q;
        hold_tag_d  = hold_tag_q;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
`ifdef IEXT_FUSE_EN
            S_PEND: begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_imm_d   = pend_imm_q;
                    out_tag_d   = pend_tag_q;
                    out_err_d   = 1'b0;
                    out_fused_d = 1'b0;
                    state_d     = S_IDLE;
                    if (accept) begin
                        if (in_op == OP_ORLOW && in_tag == pend_tag_q) begin
                            out_imm_d   = pend_imm_q | {{(DATA_W-IMM_W){1'b0}}, in_imm};
                            out_fused_d = 1'b1;
                        end else begin
                            hold_imm_d = in_imm;
                            hold_op_d  = in_op;
                            hold_tag_d = in_tag;
                            state_d    = S_HOLD;
                        end
                    end
                end
            end
`endif
            default: begin
                if (take_src) begin
`ifdef IEXT_FUSE_EN
                    if (src_op == OP_SHIFTL) begin
                        pend_imm_d = src_val;
                        pend_tag_d = src_tag;
                        state_d    = S_PEND;
                    end else begin
                        out_valid_d = 1'b1;
                        out_imm_d   = src_val;
                        out_tag_d   = src_tag;
                        out_err_d   = src_err;
                        out_fused_d = 1'b0;
                        state_d     = S_IDLE;
                    end
`else
                    out_valid_d = 1'b1;
                    out_imm_d   = src_val;
                    out_tag_d   = src_tag;
                    out_err_d   = src_err;
                    state_d     = S_IDLE;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
`ifdef IEXT_FUSE_EN
            out_fused_q <= 1'b0;
            pend_imm_q  <= '0;
            pend_tag_q  <= '0;
            hold_imm_q  <= '0;
            hold_op_q   <= '0;
            hold_tag_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_imm_q   <= out_imm_d;
            out_tag_q   <= out_tag_d;
            out_err_q   <= out_err_d;
`ifdef IEXT_FUSE_EN
            out_fused_q <= out_fused_d;
            pend_imm_q  <= pend_imm_d;
            pend_tag_q  <= pend_tag_d;
            hold_imm_q  <= hold_imm_d;
            hold_op_q   <= hold_op_d;
            hold_tag_q  <= hold_tag_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_tag   = out_tag_q;
    assign out_err   = out_err_q;
`ifdef IEXT_FUSE_EN
    assign out_fused = out_fused_q;
`else
    assign out_fused = 1'b0;
`endif

endmodule
